// File: rtl/freelist_nway.sv
// Circular free list of physical register indices with N-wide rename allocation,
// M-wide commit release, and a speculative head that ROB rollback/walk can rewind.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module freelist_nway #(
  parameter int NUM_PREGS      = 32,
  parameter int LOG_NUM_PREGS  = 5,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int INIT_BASE      = 32,
  parameter int ALLOC_WIDTH    = 2,
  parameter int FREE_WIDTH     = 2,
  parameter int WALK_WIDTH     = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [ALLOC_WIDTH-1:0]                alloc_valid,
  output logic                                  alloc_ready,
  output logic [ALLOC_WIDTH*PREG_IDX_WIDTH-1:0] alloc_preg,
  input  logic [FREE_WIDTH-1:0]                 free_valid,
  input  logic [FREE_WIDTH*PREG_IDX_WIDTH-1:0]  free_preg,
  input  logic [FREE_WIDTH-1:0]                 commit_alloc_valid,
  input  logic [1:0]                            rob_state,
  input  logic [WALK_WIDTH-1:0]                 rob_walk_valid,
  output logic [LOG_NUM_PREGS:0]                free_count,
  output logic                                  overflow_err
);

  localparam int W = PREG_IDX_WIDTH;

  typedef logic [LOG_NUM_PREGS:0]   ptr_t;
  typedef logic [LOG_NUM_PREGS-1:0] idx_t;

  // Wrap bit set, index zero: a completely full list.
  localparam ptr_t NUM_PTR = ptr_t'(NUM_PREGS);

  logic [W-1:0] entries_q [NUM_PREGS];
  ptr_t         tail_q, tail_d;
  ptr_t         spec_head_q, spec_head_d;
  ptr_t         arch_head_q, arch_head_d;
  logic         overflow_q, overflow_d;

  logic is_idle, is_rollback, is_walking;
  ptr_t alloc_cnt, alloc_ptr;
  ptr_t free_cnt, free_ptr;
  ptr_t commit_cnt, walk_cnt;
  idx_t free_addr [FREE_WIDTH];

  assign is_idle      = (rob_state == `ROB_STATE_IDLE);
  assign is_rollback  = (rob_state == `ROB_STATE_ROLLBACK);
  assign is_walking   = (rob_state == `ROB_STATE_WALK);
  assign free_count   = tail_q - spec_head_q;
  assign alloc_ready  = is_idle && (free_count >= ptr_t'(ALLOC_WIDTH));
  assign overflow_err = overflow_q;

  // Valid allocation lanes are compacted onto consecutive entries from spec_head.
  always_comb begin
    alloc_preg = '0;
    alloc_cnt  = '0;
    alloc_ptr  = spec_head_q;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (alloc_valid[k]) begin
        alloc_ptr               = spec_head_q + alloc_cnt;
        alloc_preg[k*W +: W]    = entries_q[alloc_ptr[LOG_NUM_PREGS-1:0]];
        alloc_cnt               = alloc_cnt + ptr_t'(1);
      end
    end
  end

  always_comb begin
    free_cnt = '0;
    free_ptr = tail_q;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      free_ptr     = tail_q + free_cnt;
      free_addr[j] = free_ptr[LOG_NUM_PREGS-1:0];
      if (free_valid[j]) free_cnt = free_cnt + ptr_t'(1);
    end
  end

  always_comb begin
    commit_cnt = '0;
    for (int j = 0; j < FREE_WIDTH; j++)
      if (commit_alloc_valid[j]) commit_cnt = commit_cnt + ptr_t'(1);
    walk_cnt = '0;
    for (int j = 0; j < WALK_WIDTH; j++)
      if (rob_walk_valid[j]) walk_cnt = walk_cnt + ptr_t'(1);
  end

  // Rollback uses the post-commit arch head so a same-cycle commit is not lost.
  always_comb begin
    tail_d      = tail_q + free_cnt;
    arch_head_d = arch_head_q + commit_cnt;
    spec_head_d = spec_head_q;
    if (is_rollback)      spec_head_d = arch_head_d;
    else if (is_walking)  spec_head_d = spec_head_q + walk_cnt;
    else if (alloc_ready) spec_head_d = spec_head_q + alloc_cnt;

    overflow_d = overflow_q;
    if ((|free_valid) && (ptr_t'(tail_d - arch_head_d) > NUM_PTR)) overflow_d = 1'b1;
    if (ptr_t'(spec_head_d - arch_head_d) > NUM_PTR)               overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PREGS; i++) entries_q[i] <= W'(INIT_BASE + i);
      tail_q      <= NUM_PTR;
      spec_head_q <= '0;
      arch_head_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_WIDTH; j++)
        if (free_valid[j]) entries_q[free_addr[j]] <= free_preg[j*W +: W];
      tail_q      <= tail_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_freelist_nway.sv
// Scenario bench for freelist_nway: a reference FIFO model feeds an expectation
// queue that is drained when the combinational allocation outputs are sampled.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module tb_freelist_nway;
  localparam int N  = 32;
  localparam int AW = 2;
  localparam int W  = 6;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  alloc_valid, free_valid, commit_alloc_valid, rob_state, rob_walk_valid;
  logic        alloc_ready, overflow_err;
  logic [11:0] alloc_preg, free_preg;
  logic [5:0]  free_count;

  int checks = 0;
  int errors = 0;

  logic [11:0] expPregQ[$];
  logic        expReadyQ[$];
  logic [11:0] expPreg;
  logic        expReady;

  int         modelTail, modelSpec, modelArch;
  logic [5:0] modelMem [N];
  logic       modelErr;

  freelist_nway dut (
    .clock(clock), .reset_n(reset_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_preg(alloc_preg), .free_valid(free_valid), .free_preg(free_preg),
    .commit_alloc_valid(commit_alloc_valid), .rob_state(rob_state),
    .rob_walk_valid(rob_walk_valid), .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int popCount2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) modelMem[i] = 6'(32 + i);
    modelTail = N;
    modelSpec = 0;
    modelArch = 0;
    modelErr  = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n            = 1'b0;
    alloc_valid        = '0;
    free_valid         = '0;
    free_preg          = '0;
    commit_alloc_valid = '0;
    rob_state          = `ROB_STATE_IDLE;
    rob_walk_valid     = '0;
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Drive one cycle of inputs and queue the allocation result the model predicts.
  task automatic applyStimulus(input logic [1:0] av, input logic [1:0] fv, input logic [11:0] fp,
                               input logic [1:0] cv, input logic [1:0] st, input logic [1:0] wv);
    logic [11:0] e;
    int c;
    alloc_valid        = av;
    free_valid         = fv;
    free_preg          = fp;
    commit_alloc_valid = cv;
    rob_state          = st;
    rob_walk_valid     = wv;
    e = '0;
    c = 0;
    for (int k = 0; k < AW; k++) begin
      if (av[k]) begin
        e[k*W +: W] = modelMem[(modelSpec + c) % N];
        c++;
      end
    end
    expPregQ.push_back(e);
    expReadyQ.push_back((st == `ROB_STATE_IDLE) && (modelTail - modelSpec >= AW));
  endtask

  // Advance the model with the inputs currently applied, then step one clock.
  task automatic tick();
    logic r;
    int c;
    r = (rob_state == `ROB_STATE_IDLE) && (modelTail - modelSpec >= AW);
    c = 0;
    for (int j = 0; j < 2; j++) begin
      if (free_valid[j]) begin
        modelMem[(modelTail + c) % N] = free_preg[j*W +: W];
        c++;
      end
    end
    modelTail += c;
    modelArch += popCount2(commit_alloc_valid);
    if (rob_state == `ROB_STATE_ROLLBACK)  modelSpec = modelArch;
    else if (rob_state == `ROB_STATE_WALK) modelSpec += popCount2(rob_walk_valid);
    else if (r)                            modelSpec += popCount2(alloc_valid);
    if ((free_valid != 2'b00) && (modelTail - modelArch > N)) modelErr = 1'b1;
    if (modelArch > modelSpec) modelErr = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks += 4;
    if (free_count !== 6'd32)     begin errors++; $display("[TB] FAIL reset_free_count: got %0d expected 32", free_count); end
    if (alloc_ready !== 1'b1)     begin errors++; $display("[TB] FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    if (overflow_err !== 1'b0)    begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_err); end
    if (alloc_preg !== 12'h000)   begin errors++; $display("[TB] FAIL reset_alloc_preg: got %h expected 000", alloc_preg); end
  endtask

  task automatic test_alloc_two();
    doReset();
    applyStimulus(2'b11, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    #1;
    expPreg = expPregQ.pop_front();
    expReady = expReadyQ.pop_front();
    checks += 3;
    if (alloc_preg !== expPreg)          begin errors++; $display("[TB] FAIL alloc_two_sb: got %h expected %h", alloc_preg, expPreg); end
    if (alloc_ready !== expReady)        begin errors++; $display("[TB] FAIL alloc_two_ready: got %b expected %b", alloc_ready, expReady); end
    if (alloc_preg !== {6'd33, 6'd32})   begin errors++; $display("[TB] FAIL alloc_two_lanes: got %h expected %h", alloc_preg, {6'd33, 6'd32}); end
    tick();
    applyStimulus(2'b00, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    void'(expPregQ.pop_front());
    void'(expReadyQ.pop_front());
    checks++;
    if (free_count !== 6'd30) begin errors++; $display("[TB] FAIL alloc_two_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_sparse_lane();
    doReset();
    applyStimulus(2'b10, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    #1;
    expPreg = expPregQ.pop_front();
    expReady = expReadyQ.pop_front();
    checks += 2;
    if (alloc_preg !== expPreg)         begin errors++; $display("[TB] FAIL sparse_sb: got %h expected %h", alloc_preg, expPreg); end
    if (alloc_preg !== {6'd32, 6'd0})   begin errors++; $display("[TB] FAIL sparse_lanes: got %h expected %h", alloc_preg, {6'd32, 6'd0}); end
    tick();
    checks++;
    if (free_count !== 6'd31) begin errors++; $display("[TB] FAIL sparse_count: got %0d expected 31", free_count); end
  endtask

  task automatic test_fill_backpressure();
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(2'b11, 2'b00, '0, 2'b11, `ROB_STATE_IDLE, 2'b00);
      #1;
      expPreg = expPregQ.pop_front();
      expReady = expReadyQ.pop_front();
      checks += 2;
      if (alloc_preg !== expPreg)   begin errors++; $display("[TB] FAIL fill_sb[%0d]: got %h expected %h", i, alloc_preg, expPreg); end
      if (alloc_ready !== expReady) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected %b", i, alloc_ready, expReady); end
      tick();
    end
    checks++;
    if (free_count !== 6'd2) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 2", free_count); end
    applyStimulus(2'b11, 2'b01, {6'd0, 6'd40}, 2'b11, `ROB_STATE_IDLE, 2'b00);
    #1;
    expPreg = expPregQ.pop_front();
    expReady = expReadyQ.pop_front();
    checks += 3;
    if (alloc_ready !== 1'b1)     begin errors++; $display("[TB] FAIL fill_last_ready: got %b expected 1", alloc_ready); end
    if (alloc_preg !== expPreg)   begin errors++; $display("[TB] FAIL fill_last_sb: got %h expected %h", alloc_preg, expPreg); end
    if (alloc_preg !== {6'd63, 6'd62}) begin errors++; $display("[TB] FAIL fill_last_lanes: got %h expected %h", alloc_preg, {6'd63, 6'd62}); end
    tick();
    applyStimulus(2'b11, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    #1;
    void'(expPregQ.pop_front());
    expReady = expReadyQ.pop_front();
    checks += 3;
    if (free_count !== 6'd1)      begin errors++; $display("[TB] FAIL bp_count: got %0d expected 1", free_count); end
    if (alloc_ready !== 1'b0)     begin errors++; $display("[TB] FAIL bp_ready: got %b expected 0", alloc_ready); end
    if (alloc_ready !== expReady) begin errors++; $display("[TB] FAIL bp_ready_sb: got %b expected %b", alloc_ready, expReady); end
    tick();
    checks += 2;
    if (free_count !== 6'd1)         begin errors++; $display("[TB] FAIL bp_ignored_count: got %0d expected 1", free_count); end
    if (overflow_err !== modelErr)   begin errors++; $display("[TB] FAIL bp_overflow: got %b expected %b", overflow_err, modelErr); end
  endtask

  task automatic test_wraparound();
    logic [5:0] inUse[$];
    logic [11:0] fp;
    doReset();
    applyStimulus(2'b11, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    #1;
    expPreg = expPregQ.pop_front();
    void'(expReadyQ.pop_front());
    checks++;
    if (alloc_preg !== expPreg) begin errors++; $display("[TB] FAIL wrap_first: got %h expected %h", alloc_preg, expPreg); end
    inUse.push_back(expPreg[5:0]);
    inUse.push_back(expPreg[11:6]);
    tick();
    for (int i = 1; i <= 20; i++) begin
      fp[5:0]  = inUse.pop_front();
      fp[11:6] = inUse.pop_front();
      applyStimulus(2'b11, 2'b11, fp, 2'b11, `ROB_STATE_IDLE, 2'b00);
      #1;
      expPreg = expPregQ.pop_front();
      expReady = expReadyQ.pop_front();
      checks += 2;
      if (alloc_preg !== expPreg)   begin errors++; $display("[TB] FAIL wrap_sb[%0d]: got %h expected %h", i, alloc_preg, expPreg); end
      if (alloc_ready !== expReady) begin errors++; $display("[TB] FAIL wrap_ready[%0d]: got %b expected %b", i, alloc_ready, expReady); end
      if (i == 16) begin
        checks++;
        if (alloc_preg !== {6'd33, 6'd32}) begin errors++; $display("[TB] FAIL wrap_order: got %h expected %h", alloc_preg, {6'd33, 6'd32}); end
      end
      inUse.push_back(expPreg[5:0]);
      inUse.push_back(expPreg[11:6]);
      tick();
      checks += 2;
      if (free_count !== 6'd30)   begin errors++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected 30", i, free_count); end
      if (overflow_err !== 1'b0)  begin errors++; $display("[TB] FAIL wrap_overflow[%0d]: got %b expected 0", i, overflow_err); end
    end
  endtask

  task automatic test_rollback_walk();
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
      void'(expPregQ.pop_front());
      void'(expReadyQ.pop_front());
      tick();
    end
    applyStimulus(2'b00, 2'b00, '0, 2'b11, `ROB_STATE_IDLE, 2'b00);
    void'(expPregQ.pop_front());
    void'(expReadyQ.pop_front());
    tick();
    checks++;
    if (free_count !== 6'd26) begin errors++; $display("[TB] FAIL rb_pre_count: got %0d expected 26", free_count); end
    applyStimulus(2'b11, 2'b00, '0, 2'b00, `ROB_STATE_ROLLBACK, 2'b00);
    #1;
    void'(expPregQ.pop_front());
    expReady = expReadyQ.pop_front();
    checks += 2;
    if (alloc_ready !== 1'b0)     begin errors++; $display("[TB] FAIL rb_ready: got %b expected 0", alloc_ready); end
    if (alloc_ready !== expReady) begin errors++; $display("[TB] FAIL rb_ready_sb: got %b expected %b", alloc_ready, expReady); end
    tick();
    checks++;
    if (free_count !== 6'd30) begin errors++; $display("[TB] FAIL rb_count: got %0d expected 30", free_count); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b11, 2'b00, '0, 2'b00, `ROB_STATE_WALK, 2'b11);
      #1;
      void'(expPregQ.pop_front());
      void'(expReadyQ.pop_front());
      checks++;
      if (alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL walk_ready[%0d]: got %b expected 0", i, alloc_ready); end
      tick();
    end
    checks++;
    if (free_count !== 6'd26) begin errors++; $display("[TB] FAIL walk_count: got %0d expected 26", free_count); end
    applyStimulus(2'b01, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    #1;
    expPreg = expPregQ.pop_front();
    void'(expReadyQ.pop_front());
    checks += 3;
    if (alloc_preg !== expPreg)        begin errors++; $display("[TB] FAIL walk_resume_sb: got %h expected %h", alloc_preg, expPreg); end
    if (alloc_preg !== {6'd0, 6'd38})  begin errors++; $display("[TB] FAIL walk_resume_preg: got %h expected %h", alloc_preg, {6'd0, 6'd38}); end
    if (overflow_err !== 1'b0)         begin errors++; $display("[TB] FAIL walk_overflow: got %b expected 0", overflow_err); end
    tick();
  endtask

  task automatic test_overflow();
    doReset();
    applyStimulus(2'b00, 2'b01, {6'd0, 6'd5}, 2'b00, `ROB_STATE_IDLE, 2'b00);
    void'(expPregQ.pop_front());
    void'(expReadyQ.pop_front());
    tick();
    checks += 2;
    if (overflow_err !== 1'b1)     begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow_err); end
    if (overflow_err !== modelErr) begin errors++; $display("[TB] FAIL ovf_model: got %b expected %b", overflow_err, modelErr); end
    applyStimulus(2'b00, 2'b00, '0, 2'b00, `ROB_STATE_IDLE, 2'b00);
    void'(expPregQ.pop_front());
    void'(expReadyQ.pop_front());
    tick();
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_err); end
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checks += 2;
    if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_async_clear: got %b expected 0", overflow_err); end
    if (free_count !== 6'd32)  begin errors++; $display("[TB] FAIL ovf_async_count: got %0d expected 32", free_count); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n            = 1'b0;
    alloc_valid        = '0;
    free_valid         = '0;
    free_preg          = '0;
    commit_alloc_valid = '0;
    rob_state          = `ROB_STATE_IDLE;
    rob_walk_valid     = '0;
    modelReset();
    test_reset();
    test_alloc_two();
    test_sparse_lane();
    test_fill_backpressure();
    test_wraparound();
    test_rollback_walk();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freelist_nway.md
Name: freelist_nway

Overview:
- Parametrised successor of the rename free list.
- Circular FIFO of free physical register indices with N-wide rename allocation and M-wide commit free.
- Allocation and free lanes are compacted, so valid lanes need not be contiguous.
- Keeps a speculative head and an architectural head; ROB rollback restores the speculative head and ROB walk replays surviving allocations.
- Sits between rename (alloc) and ROB commit (free).

Parameters:
- NUM_PREGS, 32: number of entries, i.e. free physical registers at reset; power of two.
- LOG_NUM_PREGS, 5: log2(NUM_PREGS).
- PREG_IDX_WIDTH, 6: physical register index width.
- INIT_BASE, 32: entry i resets to INIT_BASE+i. Indices below INIT_BASE are the architectural mapping.
- ALLOC_WIDTH, 2: rename allocation lanes.
- FREE_WIDTH, 2: commit free lanes.
- WALK_WIDTH, 2: ROB walk lanes.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  ALLOC_WIDTH  per-lane allocation request.
- alloc_ready  out  1  free list can satisfy ALLOC_WIDTH requests this cycle.
- alloc_preg  out  ALLOC_WIDTH*PREG_IDX_WIDTH  allocated index per lane; lane k uses bits [k*W +: W].
- free_valid  in  FREE_WIDTH  per-lane release of an old physical register at commit.
- free_preg  in  FREE_WIDTH*PREG_IDX_WIDTH  released indices.
- commit_alloc_valid  in  FREE_WIDTH  committing instruction owns an allocated destination; advances the architectural head.
- rob_state  in  2  compared against the `ROB_STATE_IDLE / `ROB_STATE_ROLLBACK / `ROB_STATE_WALK macros.
- rob_walk_valid  in  WALK_WIDTH  walked instruction re-claims an allocation.
- free_count  out  LOG_NUM_PREGS+1  entries between the speculative head and the tail.
- overflow_err  out  1  sticky error flag.

Behaviour:

Pointers
- Tail, speculative head and architectural head are each LOG_NUM_PREGS+1 bits: a wrap bit plus an index.
- Index arithmetic is modulo NUM_PREGS.
- free_count = tail - spec_head, taken in LOG_NUM_PREGS+1 bits.

Reset
- Entries hold INIT_BASE+i; all three pointers are 0 with the tail wrap bit set.
- free_count = NUM_PREGS; alloc_ready = 1; overflow_err = 0.
- alloc_preg is all zero; lanes with alloc_valid=0 always output 0.
- Reset asserted mid-operation discards all state immediately.

Allocation (combinational output, zero latency)
- Lane k returns the entry at spec_head + (number of valid lanes below k).
- alloc_ready = is_idle && (free_count >= ALLOC_WIDTH).
- Alloc lanes are ignored when alloc_ready = 0; the head does not move.
- Otherwise spec_head advances by popcount(alloc_valid) at the clock edge.

Free
- The j-th valid free lane, counted in compacted order, writes entry tail+j.
- Tail advances by popcount(free_valid).
- Frees are accepted in every rob_state.
- arch_head advances by popcount(commit_alloc_valid) in every state.

Rollback (is_rollback)
- spec_head <= arch_head; allocation is disabled.

Walk (is_walking)
- spec_head advances by popcount(rob_walk_valid); allocation is disabled.

Free count and errors
- free_count reflects the pointers after the edge; no bypass of same-cycle frees to allocation.
- Same-cycle alloc and free: the free count updates by frees minus accepted allocations.
- overflow_err sets, and stays set until reset, if:
  - a free would make tail - arch_head exceed NUM_PREGS, or
  - arch_head would pass spec_head.
- An overflowing free is still written.

Test Plan:
- Reset, then alloc_valid=2'b11 for one cycle -> alloc_preg lanes 32 and 33; next cycle free_count=30.
- alloc_valid=2'b10 right after reset -> lane1=32, lane0=0; spec_head +1.
- Allocate 2 per cycle for 15 cycles, leaving free_count=2:
  - free_valid=2'b01 with preg 40 and alloc_valid=2'b11 in the same cycle -> allocation accepted.
  - Next cycle free_count=1 and alloc_ready=0; further alloc requests are ignored.
- Wrap-around: free and allocate indices across entry 31 -> 0 -> FIFO order preserved and free_count stays correct.
- Rollback:
  - Allocate 6, commit_alloc_valid covers 2, rob_state=ROLLBACK one cycle -> free_count=30.
  - Then WALK with rob_walk_valid=2'b11 two cycles -> free_count=26 and alloc_ready=0 throughout.
  - Then IDLE -> next alloc returns preg 38.
- Free with free_count=NUM_PREGS -> overflow_err=1, stays 1 until reset_n pulses low.
